// File: rtl/timer_unit.sv
// Programmable timer: free-running 16-bit divider exposed as DIV, an
// 8-bit counter TIMA clocked from a selectable divider tap, a reload
// value TMA, a control register TAC and a level interrupt request.
// Register window FF04-FF07; reads are registered with one clock latency.
module timer_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] A,
    input  logic [7:0]  Di,
    output logic [7:0]  Do,
    input  logic        wr_n,
    input  logic        rd_n,
    input  logic        cs,
    output logic        int_req,
    input  logic        int_ack
);

    localparam logic [15:0] ADDR_DIV  = 16'hFF04;
    localparam logic [15:0] ADDR_TIMA = 16'hFF05;
    localparam logic [15:0] ADDR_TMA  = 16'hFF06;
    localparam logic [15:0] ADDR_TAC  = 16'hFF07;

    logic [15:0] div_cnt_q, div_cnt_d;
    logic [7:0]  tima_q, tima_d;
    logic [7:0]  tma_q, tma_d;
    logic [2:0]  tac_q, tac_d;
    logic        int_req_q, int_req_d;
    logic [7:0]  reg_out_q, reg_out_d;

    logic wr_en_s, rd_en_s;
    logic div_wr_s, tima_wr_s, tma_wr_s, tac_wr_s;
    logic tap_ones_s, tick_s, overflow_s;

    // Bus strobe qualification and write address decode.
    always_comb begin
        wr_en_s   = cs & ~wr_n;
        rd_en_s   = cs & wr_n & ~rd_n;
        div_wr_s  = wr_en_s & (A == ADDR_DIV);
        tima_wr_s = wr_en_s & (A == ADDR_TIMA);
        tma_wr_s  = wr_en_s & (A == ADDR_TMA);
        tac_wr_s  = wr_en_s & (A == ADDR_TAC);
    end

    // Tick when the selected low divider bits are all ones; the registered
    // TAC is used, so a TAC write only affects tick generation next cycle.
    always_comb begin
        case (tac_q[1:0])
            2'b00:   tap_ones_s = &div_cnt_q[9:0];
            2'b01:   tap_ones_s = &div_cnt_q[3:0];
            2'b10:   tap_ones_s = &div_cnt_q[5:0];
            2'b11:   tap_ones_s = &div_cnt_q[7:0];
            default: tap_ones_s = 1'b0;
        endcase
        tick_s     = tac_q[2] & ~div_wr_s & tap_ones_s;
        // A CPU write to TIMA in the tick cycle suppresses the overflow.
        overflow_s = tick_s & (tima_q == 8'hFF) & ~tima_wr_s;
    end

    // Next-state for divider, counter, reload, control and interrupt.
    always_comb begin
        if (div_wr_s) begin
            div_cnt_d = 16'h0000;
        end else begin
            div_cnt_d = div_cnt_q + 16'h0001;
        end

        if (tma_wr_s) begin
            tma_d = Di;
        end else begin
            tma_d = tma_q;
        end

        if (tac_wr_s) begin
            tac_d = Di[2:0];
        end else begin
            tac_d = tac_q;
        end

        if (tima_wr_s) begin
            tima_d = Di;
        end else if (overflow_s) begin
            // Reload uses the freshly written TMA when both coincide.
            tima_d = tma_d;
        end else if (tick_s) begin
            tima_d = tima_q + 8'h01;
        end else begin
            tima_d = tima_q;
        end

        if (overflow_s) begin
            int_req_d = 1'b1;
        end else if (int_ack) begin
            int_req_d = 1'b0;
        end else begin
            int_req_d = int_req_q;
        end
    end

    // Read data capture; unmapped addresses leave the last value in place.
    always_comb begin
        reg_out_d = reg_out_q;
        if (rd_en_s) begin
            case (A)
                ADDR_DIV:  reg_out_d = div_cnt_q[15:8];
                ADDR_TIMA: reg_out_d = tima_q;
                ADDR_TMA:  reg_out_d = tma_q;
                ADDR_TAC:  reg_out_d = {5'b11111, tac_q};
                default:   reg_out_d = reg_out_q;
            endcase
        end else begin
            reg_out_d = reg_out_q;
        end
    end

    // State registers; reset overrides any concurrent write, tick or overflow.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt_q <= 16'h0000;
            tima_q    <= 8'h00;
            tma_q     <= 8'h00;
            tac_q     <= 3'b000;
            int_req_q <= 1'b0;
            reg_out_q <= 8'h00;
        end else begin
            div_cnt_q <= div_cnt_d;
            tima_q    <= tima_d;
            tma_q     <= tma_d;
            tac_q     <= tac_d;
            int_req_q <= int_req_d;
            reg_out_q <= reg_out_d;
        end
    end

    assign Do      = cs ? reg_out_q : 8'hFF;
    assign int_req = int_req_q;

endmodule

// File: tb/tb_timer_unit.sv
// Scoreboard bench for timer_unit: stimulus pushes expected values, a
// monitor pops them whenever a read strobe or probe makes an output visible.
module tb_timer_unit;

    logic        clock;
    logic        reset;
    logic [15:0] A;
    logic [7:0]  Di;
    logic [7:0]  Do;
    logic        wr_n;
    logic        rd_n;
    logic        cs;
    logic        int_req;
    logic        int_ack;

    // probe: 0 none, 1 compare Do, 2 compare int_req (value after the edge)
    logic [1:0]  probe;

    typedef struct {
        string      name;
        logic [7:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    logic       mon_rd;
    logic [1:0] mon_probe;
    exp_t       mon_e;
    logic [7:0] mon_act;

    timer_unit dut (
        .clock   (clock),
        .reset   (reset),
        .A       (A),
        .Di      (Di),
        .Do      (Do),
        .wr_n    (wr_n),
        .rd_n    (rd_n),
        .cs      (cs),
        .int_req (int_req),
        .int_ack (int_ack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: detect an output event at the edge, compare just after it.
    always @(posedge clock) begin
        mon_rd    = cs && wr_n && !rd_n && !reset;
        mon_probe = probe;
        #1;
        if (mon_rd || mon_probe != 2'd0) begin
            checks = checks + 1;
            if (mon_probe == 2'd2) mon_act = {7'b0000000, int_req};
            else                   mon_act = Do;
            if (sb_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_output: got %02h, no expected value queued", mon_act);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_act !== mon_e.exp) begin
                    errors = errors + 1;
                    $display("FAIL %s: got %02h, expected %02h", mon_e.name, mon_act, mon_e.exp);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic bus_idle();
        cs = 1'b0; wr_n = 1'b1; rd_n = 1'b1; A = 16'h0000; Di = 8'h00;
        int_ack = 1'b0; probe = 2'd0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic wr(input logic [15:0] addr, input logic [7:0] data);
        cs = 1'b1; wr_n = 1'b0; A = addr; Di = data;
        @(negedge clock);
        bus_idle();
    endtask

    task automatic rd(input logic [15:0] addr, input logic [7:0] exp, input string name);
        exp_t e;
        e.name = name; e.exp = exp;
        sb_q.push_back(e);
        cs = 1'b1; rd_n = 1'b0; A = addr;
        @(negedge clock);
        bus_idle();
    endtask

    task automatic chk_irq(input logic exp, input logic ack, input string name);
        exp_t e;
        e.name = name; e.exp = {7'b0000000, exp};
        sb_q.push_back(e);
        probe = 2'd2; int_ack = ack;
        @(negedge clock);
        bus_idle();
    endtask

    initial begin
        bus_idle();
        reset = 1'b1;
        idle(3);
        reset = 1'b0;

        // DIV after 512 clocks from reset release
        idle(512);
        rd(16'hFF04, 8'h02, "div_after_512");
        chk_irq(1'b0, 1'b0, "irq_reset");
        rd(16'hFF05, 8'h00, "tima_reset");
        rd(16'hFF06, 8'h00, "tma_reset");
        rd(16'hFF07, 8'hF8, "tac_reset");
        rd(16'hFF03, 8'hF8, "unmapped_read_holds");

        // Rate 16: TIMA FE -> FF after 16 clocks, then overflow to TMA=00
        wr(16'hFF07, 8'h05);
        wr(16'hFF05, 8'hFE);
        wr(16'hFF04, 8'h00);               // edge W
        idle(16);                          // W+1..W+16 (tick at W+16)
        rd(16'hFF05, 8'hFF, "tima_ff_after_16");   // W+17
        idle(13);                          // W+18..W+30
        chk_irq(1'b0, 1'b0, "irq_before_ovf");      // W+31
        chk_irq(1'b1, 1'b0, "irq_on_ovf");          // W+32 overflow
        rd(16'hFF05, 8'h00, "tima_reload_tma0");    // W+33
        chk_irq(1'b0, 1'b1, "irq_ack_clear");       // W+34

        // Reload from TMA=F0, int_req holds until acknowledged
        wr(16'hFF06, 8'hF0);
        wr(16'hFF05, 8'hFF);
        wr(16'hFF04, 8'h00);               // edge W2
        idle(14);
        chk_irq(1'b0, 1'b0, "irq_pre_ovf2");        // W2+15
        chk_irq(1'b1, 1'b0, "irq_ovf2");            // W2+16
        rd(16'hFF05, 8'hF0, "tima_reload_f0");      // W2+17
        idle(99);
        chk_irq(1'b1, 1'b0, "irq_hold_100");
        chk_irq(1'b0, 1'b1, "irq_ack_pulse");
        chk_irq(1'b0, 1'b0, "irq_stays_clear");

        // Overflow coincident with ack: set wins
        wr(16'hFF05, 8'hFF);
        wr(16'hFF04, 8'h00);               // W3
        idle(15);
        chk_irq(1'b1, 1'b1, "irq_set_beats_ack");   // W3+16
        chk_irq(1'b0, 1'b1, "irq_ack_after");
        rd(16'hFF05, 8'hF0, "tima_after_ack_ovf");

        // TIMA write coincident with an overflowing tick
        wr(16'hFF05, 8'hFF);
        wr(16'hFF04, 8'h00);               // W4
        idle(15);
        wr(16'hFF05, 8'h55);               // W4+16 tick
        chk_irq(1'b0, 1'b0, "irq_tima_wr_wins");
        rd(16'hFF05, 8'h55, "tima_wr_wins");

        // TMA write coincident with overflow reloads with the new value
        wr(16'hFF05, 8'hFF);
        wr(16'hFF04, 8'h00);               // W5
        idle(15);
        wr(16'hFF06, 8'h3C);               // W5+16 overflow
        rd(16'hFF05, 8'h3C, "tima_reload_new_tma");
        rd(16'hFF06, 8'h3C, "tma_new");
        chk_irq(1'b1, 1'b0, "irq_tma_wr_ovf");
        wr(16'hFF05, 8'h80);

        // Reset with int_req=1, TIMA=80 and a concurrent TIMA write
        reset = 1'b1;
        cs = 1'b1; wr_n = 1'b0; A = 16'hFF05; Di = 8'h77;
        chk_irq(1'b0, 1'b0, "irq_cleared_by_reset");  // edge R
        reset = 1'b0;
        rd(16'hFF05, 8'h00, "tima_after_reset");      // R+1
        rd(16'hFF07, 8'hF8, "tac_after_reset");       // R+2
        rd(16'hFF06, 8'h00, "tma_after_reset");       // R+3
        idle(40);                                     // R+4..R+43
        rd(16'hFF05, 8'h00, "no_ticks_tac_off");      // R+44
        idle(210);                                    // R+45..R+254
        rd(16'hFF04, 8'h00, "div_254");               // R+255
        rd(16'hFF04, 8'h00, "div_255");               // R+256
        rd(16'hFF04, 8'h01, "div_256");               // R+257

        // Chip select gating and TAC readback
        probe = 2'd1;
        begin
            exp_t e;
            e.name = "cs_low_ff"; e.exp = 8'hFF;
            sb_q.push_back(e);
        end
        @(negedge clock);
        bus_idle();
        wr(16'hFF07, 8'hFF);
        rd(16'hFF07, 8'hFF, "tac_ff_read");
        wr(16'hFF07, 8'h04);
        rd(16'hFF07, 8'hFC, "tac_04_read");
        idle(2);

        checks = checks + 1;
        if (sb_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_unit.md
TIMER_UNIT -- requirements
Module: timer_unit

Interface
REQ-001 Reset is `reset`, synchronous, active-high; the clock is `clock`.
REQ-002 `clock`  in  1  system clock (4.194304 MHz); all state changes on its rising edge.
REQ-003 `reset`  in  1  synchronous active-high reset.
REQ-004 `A`  in  16  bus address.
REQ-005 `Di`  in  8  write data.
REQ-006 `Do`  out  8  read data; equals `reg_out` when `cs`=1, else 8'hFF (combinational).
REQ-007 `wr_n`  in  1  active-low write strobe.
REQ-008 `rd_n`  in  1  active-low read strobe.
REQ-009 `cs`  in  1  chip select from external decode of FF04–FF07.
REQ-010 `int_req`  out  1  timer interrupt request, level; drives `int_req[2]` of the interrupt controller.
REQ-011 `int_ack`  in  1  acknowledge pulse from the interrupt controller (`int_ack[2]`).

Function
REQ-012 Internal 16-bit `div_cnt` SHALL increment by 1 every clock and wrap from FFFF to 0000.
REQ-013 DIV (FF04) read value SHALL be `div_cnt[15:8]`.
REQ-014 A write to FF04 (any `Di`) SHALL set `div_cnt` to 0 on that edge; no TIMA tick is generated that cycle.
REQ-015 TAC (FF07) SHALL be 3 bits:
- bit 2: enable.
- bits 1:0: rate select — 00 = 1024 clocks, 01 = 16, 10 = 64, 11 = 256.
REQ-016 `tick` SHALL be asserted in a cycle when TAC[2]=1, no DIV write occurs, and `div_cnt[k-1:0]` is all ones. k = 10/4/6/8 for select 00/01/10/11.
REQ-017 On `tick` with TIMA != FF, TIMA SHALL increment by 1 on that edge.
REQ-018 On `tick` with TIMA = FF (overflow), on the same edge: TIMA SHALL load TMA, and `int_req` SHALL be set to 1.
REQ-019 `int_req` SHALL stay 1 until a cycle with `int_ack`=1, then clear on that edge.
REQ-020 If overflow and `int_ack`=1 occur in the same cycle, `int_req` SHALL be 1 (set wins).
REQ-021 Writes SHALL occur when `cs`=1, `wr_n`=0 and `A` matches:
- FF05 → TIMA.
- FF06 → TMA.
- FF07 → TAC[2:0] from `Di[2:0]`.
- Other addresses are ignored.
REQ-022 A TIMA write in the same cycle as a `tick` SHALL win: TIMA = `Di`, no increment, no reload, no `int_req` set.
REQ-023 A TMA write in the same cycle as an overflow SHALL reload TIMA with `Di` and update TMA to `Di`.
REQ-024 A TAC write SHALL take effect for `tick` evaluation from the next cycle onward.
REQ-025 Reads SHALL apply when `cs`=1, `wr_n`=1, `rd_n`=0; `reg_out` loads on the edge:
- FF04 → DIV.
- FF05 → TIMA.
- FF06 → TMA.
- FF07 → {5'b11111, TAC}.
- Other addresses: `reg_out` holds.
REQ-026 Read latency SHALL be one clock; `Do` reflects the value registered at the end of the strobe cycle.
REQ-027 Reads SHALL have no side effects.

Reset
REQ-028 When `reset`=1 at a rising edge, the following SHALL clear to 0: `div_cnt`, TIMA, TMA, TAC, `int_req`, `reg_out`.
REQ-029 Reset SHALL override any simultaneous write, tick or overflow.
REQ-030 Reset asserted mid-count SHALL discard pending progress; counting restarts from `div_cnt`=0 the cycle after `reset` deasserts.

Verification
REQ-031 Reset, then 512 clocks, then read FF04 → `Do`=8'h02; `int_req`=0.
REQ-032 Write TAC=3'b101, then TIMA=8'hFE, then DIV (resets `div_cnt`):
- TIMA=8'hFF 16 clocks after the DIV write.
- Next tick: TIMA=TMA(8'h00), `int_req`=1.
REQ-033 TMA=8'hF0, TAC=3'b101, TIMA=8'hFF:
- Overflow → TIMA=8'hF0, `int_req`=1.
- `int_req` holds for 100 clocks with `int_ack`=0.
- 1-cycle `int_ack` pulse → `int_req`=0 next edge.
REQ-034 Overflow coincident with `int_ack`=1 → `int_req`=1 after the edge. TIMA write (8'h55) coincident with a tick → TIMA=8'h55, no increment.
REQ-035 Assert `reset` while `int_req`=1 and TIMA=8'h80 → next edge: `int_req`=0, TIMA=0, TAC=0; no ticks while TAC[2]=0.
REQ-036 `cs`=0 → `Do`=8'hFF. Write TAC 8'hFF then read FF07 → 8'hFF. Write TAC 8'h04 then read FF07 → 8'hFC.
